// File: rtl/aes_encipher_block_if.sv
// Block-side bus of the AES-128 encipher core: start/ready handshake,
// round-key select and the byte-wide forward S-box ROM pins.
interface aes_encipher_block_if;
    logic         next;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
    logic         busy;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [7:0]   rom_addr;
    logic [7:0]   rom_data;
    logic         rom_ce_n;
    logic         rom_oe_n;

    modport slave (
        input  next, block, round_key, rom_data,
        output new_block, ready, busy, round, rom_addr, rom_ce_n, rom_oe_n
    );

    modport master (
        output next, block, round_key, rom_data,
        input  new_block, ready, busy, round, rom_addr, rom_ce_n, rom_oe_n
    );
endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES-128 encipher core; SubBytes goes byte-serially through an external S-box ROM.
// Define AES_ENC_ROM_PIPE_EN to issue one ROM address per cycle (ROM must accept back-to-back reads).
module aes_encipher_block #(
    parameter int ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    aes_encipher_block_if.slave bus
);
    typedef logic [15:0][7:0] state_t;  // byte i lives at st[15-i], i.e. st[~i]
    typedef enum logic [2:0] {IDLE, SUB_ADDR, SUB_WAIT, SHIFTMIX, ADDKEY, DONE} fsm_t;

`ifdef AES_ENC_ROM_PIPE_EN
    localparam bit PIPE = 1'b1;
    logic [4:0] ctr;
`else
    localparam bit PIPE = 1'b0;
    localparam logic [2:0] LAT_LAST = 3'((ROM_LAT == 0) ? 0 : ROM_LAT - 1);
    logic [3:0] ctr;
    logic [2:0] wcnt;
`endif

    fsm_t         state, state_nxt;
    state_t       st;
    logic [3:0]   round;
    logic [127:0] new_block;
    logic         ready, busy;
    logic         cap;
    logic [3:0]   cap_idx, addr_idx;
    logic         rom_en_n;
    logic [7:0]   rom_addr;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[15 - (r + 4*c)] = s[15 - (r + 4*((c + r) % 4))];
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[15 - 4*c]; a1 = s[14 - 4*c]; a2 = s[13 - 4*c]; a3 = s[12 - 4*c];
            o[15 - 4*c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[14 - 4*c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[13 - 4*c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[12 - 4*c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

`ifdef AES_ENC_ROM_PIPE_EN
    // ctr counts address cycles; byte ctr-ROM_LAT lands this cycle
    assign cap      = (state == SUB_ADDR) && (ctr >= 5'(ROM_LAT));
    assign cap_idx  = 4'(ctr - 5'(ROM_LAT));
    assign addr_idx = ctr[4] ? 4'hf : ctr[3:0];
`else
    assign cap      = ((state == SUB_ADDR) && (ROM_LAT == 0)) ||
                      ((state == SUB_WAIT) && (wcnt == LAT_LAST));
    assign cap_idx  = ctr;
    assign addr_idx = ctr;

    always_ff @(posedge clk) begin
        if (reset || state != SUB_WAIT) wcnt <= '0;
        else                            wcnt <= wcnt + 3'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.next) state_nxt = SUB_ADDR;
            SUB_ADDR, SUB_WAIT: begin
                if (cap && cap_idx == 4'hf) state_nxt = SHIFTMIX;
                else if (!PIPE)             state_nxt = cap ? SUB_ADDR : SUB_WAIT;
            end
            SHIFTMIX: state_nxt = ADDKEY;
            ADDKEY:   state_nxt = (round == 4'd10) ? DONE : SUB_ADDR;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rom_en_n = 1'b1;
        rom_addr = 8'h00;
        if (state == SUB_ADDR || state == SUB_WAIT) begin
            rom_en_n = 1'b0;
            rom_addr = st[~addr_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= '0;
            ctr       <= '0;
            round     <= '0;
            new_block <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: if (bus.next) begin
                    st    <= bus.block ^ bus.round_key;
                    round <= 4'd1;
                    ctr   <= '0;
                    busy  <= 1'b1;
                end
                SUB_ADDR, SUB_WAIT: begin
                    if (cap)         st[~cap_idx] <= bus.rom_data;
                    if (PIPE || cap) ctr <= ctr + 1'b1;
                end
                SHIFTMIX: st <= (round == 4'd10) ? shift_rows(st) : mix_columns(shift_rows(st));
                ADDKEY: begin
                    st <= st ^ bus.round_key;
                    if (round != 4'd10) begin
                        round <= round + 4'd1;
                        ctr   <= '0;
                    end
                end
                DONE: begin
                    new_block <= st;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                    round     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.round     = round;
    assign bus.new_block = new_block;
    assign bus.ready     = ready;
    assign bus.busy      = busy;
    assign bus.rom_addr  = rom_addr;
    assign bus.rom_ce_n  = rom_en_n;
    assign bus.rom_oe_n  = rom_en_n;
endmodule
